// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one 16-bit {rw, addr[6:0], data[7:0]} frame per
// request, MSB first, with a request/response handshake around each frame.
// The read byte is shifted in from CIPO during the data byte.
`timescale 1ns/1ps
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_cs,
  input  logic       spi_cipo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  // Phase-counter reload values: each phase runs for (load + 1) cycles.
  // The IDLE cycle in which the next request is taken counts as the last
  // cs-high cycle, so the GAP phase itself lasts CS_IDLE-1 cycles.
  localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LOAD   = (CS_IDLE > 1) ? 8'(CS_IDLE - 2) : 8'd0;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  rx_q, rx_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cnt_done;

  assign cnt_done = (cnt_q == 8'd0);

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    copi_d      = copi_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          frame_d   = {req_rw, req_addr, req_wdata};
          bit_idx_d = 4'd15;
          rx_d      = 8'h00;
          cnt_d     = SETUP_LOAD;
          cs_d      = 1'b0;
          copi_d    = req_rw;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_done) begin
          cnt_d   = DIV_LOAD;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_LOW: begin
        if (cnt_done) begin
          // Rising sclk edge: capture CIPO only during the data byte.
          sclk_d  = 1'b1;
          cnt_d   = DIV_LOAD;
          state_d = S_HIGH;
          if (bit_idx_q <= 4'd7) begin
            rx_d = {rx_q[6:0], spi_cipo};
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_HIGH: begin
        if (cnt_done) begin
          // Falling sclk edge: COPI advances together with it.
          sclk_d = 1'b0;
          if (bit_idx_q == 4'd0) begin
            copi_d  = 1'b0;
            cnt_d   = HOLD_LOAD;
            state_d = S_HOLD;
          end else begin
            bit_idx_d = bit_idx_q - 4'd1;
            copi_d    = frame_q[bit_idx_q - 4'd1];
            cnt_d     = DIV_LOAD;
            state_d   = S_LOW;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_HOLD: begin
        if (cnt_done) begin
          cs_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = frame_q[15] ? 8'h00 : rx_q;
          if (CS_IDLE > 1) begin
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            cnt_d   = 8'd0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_GAP: begin
        if (cnt_done) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any frame in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bit_idx_q   <= 4'd0;
      frame_q     <= 16'h0000;
      rx_q        <= 8'h00;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      copi_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      copi_q      <= copi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign spi_cs    = cs_q;
  assign spi_sclk  = sclk_q;
  assign spi_copi  = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: default-parameter instance looped back to a
// small register-file peripheral model, plus a fast-timing instance.
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int CS_LOW   = CS_SETUP + 32 * CLK_DIV + CS_HOLD;   // 132
  localparam int F_LOW    = 1 + 32 * 1 + 1;                     // 34

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // default-timing instance
  logic       req_valid, req_rw, req_ready, rsp_valid, busy;
  logic [6:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic       spi_sclk, spi_copi, spi_cs;
  logic       spi_cipo = 1'b0;

  // fast-timing instance
  logic       f_req_valid, f_req_rw, f_req_ready, f_rsp_valid, f_busy;
  logic [6:0] f_req_addr;
  logic [7:0] f_req_wdata, f_rsp_rdata;
  logic       f_sclk, f_copi, f_cs;
  logic       f_cipo = 1'b1;

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_sclk(spi_sclk), .spi_copi(spi_copi), .spi_cs(spi_cs), .spi_cipo(spi_cipo));

  spi_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_rw(f_req_rw), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
    .spi_sclk(f_sclk), .spi_copi(f_copi), .spi_cs(f_cs), .spi_cipo(f_cipo));

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // scoreboard queues, filled by the stimulus when a request is issued
  logic [15:0] exp_frame[$];
  logic [7:0]  exp_rsp[$];
  logic [15:0] f_exp_frame[$];
  logic [7:0]  f_exp_rsp[$];

  // cycle counter and accept-edge timestamps
  int cyc = 0, t0 = 0, f_t0 = 0;
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) t0 = cyc;
    if (rst_n && f_req_valid && f_req_ready) f_t0 = cyc;
    cyc = cyc + 1;
  end

  // stimulus-owned mode flags
  bit abort_exp = 1'b0;
  bit b2b_mode  = 1'b0;

  // peripheral register file (addresses 0..4), reg 2 preloaded with 0xA5
  logic [7:0] regs [5] = '{8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};

  // frame monitor + peripheral model for the default instance
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  int          m_low = 0, m_high = 0, m_rises = 0, m_first = 0;
  int          copi_unstable = 0, ready_err = 0;
  logic [15:0] m_bits = 16'h0;
  logic [7:0]  rd_byte = 8'h00;
  bit          b2b_armed = 1'b0, in_post = 1'b0;
  always @(negedge clk) begin
    logic [15:0] ef;
    if (!spi_cs && prev_cs) begin
      if (b2b_armed) check("cs_high_gap", m_high, CS_IDLE);
      b2b_armed = b2b_mode;
      in_post = 1'b0;
      m_low = 0; m_rises = 0; m_bits = 16'h0; spi_cipo = 1'b0;
    end
    if (spi_cs && !prev_cs) m_high = 0;
    if (!spi_cs) m_low++; else m_high++;
    if (spi_sclk && !prev_sclk) begin
      m_rises++;
      m_bits = {m_bits[14:0], spi_copi};
      if (spi_copi !== prev_copi) copi_unstable++;
      if (m_rises == 1) m_first = cyc - t0;
      if (m_rises == 8) rd_byte = (m_bits[6:0] < 7'd5) ? regs[m_bits[2:0]] : 8'h00;
    end
    if (!spi_sclk && prev_sclk && m_rises >= 8 && m_rises < 16) spi_cipo = rd_byte[15 - m_rises];
    if (spi_cs && !prev_cs) begin
      if (abort_exp) begin
        check("abort_partial_rises", m_rises, 7);
      end else if (exp_frame.size() == 0) begin
        check("frame_unexpected", exp_frame.size(), 1);
      end else begin
        ef = exp_frame.pop_front();
        check("copi_bits", m_bits, ef);
        check("sclk_rises", m_rises, 16);
        check("cs_low_cycles", m_low, CS_LOW);
        check("first_rise", m_first, 1 + CS_SETUP + CLK_DIV);
        if (m_rises == 16 && m_bits[15] && m_bits[14:8] < 7'd5) regs[m_bits[10:8]] = m_bits[7:0];
        in_post = 1'b1;
      end
    end
    if (rst_n) begin
      if (!spi_cs && req_ready) ready_err++;
      if (spi_cs && in_post && (req_ready !== (m_high >= CS_IDLE))) ready_err++;
      if (busy === req_ready) ready_err++;
    end
    prev_cs = spi_cs; prev_sclk = spi_sclk; prev_copi = spi_copi;
  end

  // response monitor for the default instance
  logic rsp_prev = 1'b0, cs_prev_r = 1'b1;
  always @(negedge clk) begin
    if (rsp_valid) begin
      check("rsp_pulse_width", rsp_prev, 0);
      check("rsp_at_cs_rise", {cs_prev_r, spi_cs}, 2'b01);
      if (exp_rsp.size() == 0) check("rsp_unexpected", exp_rsp.size(), 1);
      else check("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
    end
    rsp_prev = rsp_valid; cs_prev_r = spi_cs;
  end

  // frame and response monitor for the fast instance
  logic        fp_cs = 1'b1, fp_sclk = 1'b0;
  int          f_low = 0, f_rises = 0, f_first = 0, f_err = 0;
  logic [15:0] f_bits = 16'h0;
  always @(negedge clk) begin
    if (!f_cs && fp_cs) begin f_low = 0; f_rises = 0; f_bits = 16'h0; end
    if (!f_cs) f_low++;
    if (f_sclk && !fp_sclk) begin
      f_rises++;
      f_bits = {f_bits[14:0], f_copi};
      if (f_rises == 1) f_first = cyc - f_t0;
    end
    if (f_cs && !fp_cs) begin
      if (f_exp_frame.size() == 0) check("fast_frame_unexpected", f_exp_frame.size(), 1);
      else begin
        check("fast_copi_bits", f_bits, f_exp_frame.pop_front());
        check("fast_sclk_rises", f_rises, 16);
        check("fast_cs_low_cycles", f_low, F_LOW);
        check("fast_first_rise", f_first, 3);
      end
    end
    if (f_rsp_valid) begin
      if (f_exp_rsp.size() == 0) check("fast_rsp_unexpected", f_exp_rsp.size(), 1);
      else check("fast_rsp_rdata", f_rsp_rdata, f_exp_rsp.pop_front());
    end
    if (rst_n && (f_busy === f_req_ready)) f_err++;
    fp_cs = f_cs; fp_sclk = f_sclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one request; expected frame and response go to the scoreboard now
  task automatic send(input bit f, input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input logic [7:0] rd);
    int n = 0;
    if (f) begin
      f_exp_frame.push_back({rw, a, d}); f_exp_rsp.push_back(rw ? 8'h00 : rd);
    end else begin
      exp_frame.push_back({rw, a, d}); exp_rsp.push_back(rw ? 8'h00 : rd);
    end
    tick();
    if (f) begin f_req_valid = 1'b1; f_req_rw = rw; f_req_addr = a; f_req_wdata = d; end
    else   begin req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d; end
    while (!(f ? f_req_ready : req_ready) && n < 2000) begin tick(); n++; end
    if (n >= 2000) check("accept_timeout", n, 0);
    tick();
    if (f) f_req_valid = 1'b0; else req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin tick(); n++; end
    while ((exp_rsp.size() != 0 || f_exp_rsp.size() != 0 || !req_ready || !f_req_ready) && n < 5000);
    if (n >= 5000) check("done_timeout", n, 0);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 7'h00; req_wdata = 8'h00;
    f_req_valid = 1'b0; f_req_rw = 1'b0; f_req_addr = 7'h00; f_req_wdata = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_cs", spi_cs, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_copi", spi_copi, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: write 0x04 <- 0x80
    send(0, 1'b1, 7'h04, 8'h80, 8'h00);
    wait_done();

    // 2: read 0x02, peripheral returns 0xA5
    send(0, 1'b0, 7'h02, 8'h3C, 8'hA5);
    wait_done();
    repeat (5) tick();
    check("rdata_hold", rsp_rdata, 8'hA5);

    // 3: three frames with req_valid held high throughout
    exp_frame.push_back(16'h9011); exp_rsp.push_back(8'h00);
    exp_frame.push_back(16'h9122); exp_rsp.push_back(8'h00);
    exp_frame.push_back(16'h9233); exp_rsp.push_back(8'h00);
    b2b_mode = 1'b1;
    tick();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h10; req_wdata = 8'h11;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!req_ready && n < 2000) begin tick(); n++; end
      if (n >= 2000) check("b2b_accept_timeout", n, 0);
      tick();
      req_addr = 7'h11 + 7'(k); req_wdata = 8'h22 + 8'(k * 8'h11);
    end
    req_valid = 1'b0;
    b2b_mode = 1'b0;
    wait_done();

    // 4: reset after 7 sclk rises, then a normal write
    send(0, 1'b1, 7'h03, 8'h3C, 8'h00);
    tick();
    n = 0;
    while (m_rises < 7 && n < 2000) begin tick(); n++; end
    if (n >= 2000) check("abort_wait_timeout", n, 0);
    abort_exp = 1'b1;
    void'(exp_frame.pop_back());
    void'(exp_rsp.pop_back());
    rst_n = 1'b0;
    #1;
    check("abort_cs", spi_cs, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_copi", spi_copi, 0);
    check("abort_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    abort_exp = 1'b0;
    repeat (5) tick();
    check("abort_reg3_untouched", regs[3], 8'h00);
    send(0, 1'b1, 7'h00, 8'hFF, 8'h00);
    wait_done();
    check("post_abort_reg0", regs[0], 8'hFF);

    // 5: fast timing instance, one write and one read (CIPO tied high)
    send(1, 1'b1, 7'h2A, 8'h96, 8'h00);
    send(1, 1'b0, 7'h11, 8'h00, 8'hFF);
    wait_done();

    // 6: loopback writes, an out-of-range write and a read
    send(0, 1'b1, 7'h00, 8'hF0, 8'h00);
    send(0, 1'b1, 7'h01, 8'hCC, 8'h00);
    send(0, 1'b1, 7'h02, 8'hAA, 8'h00);
    send(0, 1'b1, 7'h03, 8'h55, 8'h00);
    send(0, 1'b1, 7'h04, 8'h80, 8'h00);
    send(0, 1'b1, 7'h05, 8'h77, 8'h00);
    send(0, 1'b0, 7'h01, 8'h00, 8'hCC);
    wait_done();
    check("reg0", regs[0], 8'hF0);
    check("reg1", regs[1], 8'hCC);
    check("reg2", regs[2], 8'hAA);
    check("reg3", regs[3], 8'h55);
    check("reg4", regs[4], 8'h80);

    check("rsp_queue_drained", exp_rsp.size() + f_exp_rsp.size(), 0);
    check("frame_queue_drained", exp_frame.size() + f_exp_frame.size(), 0);
    check("copi_stable_at_rise", copi_unstable, 0);
    check("ready_busy_timing", ready_err, 0);
    check("fast_ready_busy", f_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 initiator that serialises one 16-bit register-access frame per request, MSB first: {rw[15], addr[14:8], data[7:0]}. It drives the chip's SPI register-file peripheral from test/debug logic and on-chip sequencers. A request/response handshake wraps each frame. CIPO is captured during the data byte so read frames return 8 bits.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; legal 1..255; interop with a same-clock 3-FF-synchronised peripheral requires >=4
CS_SETUP, 2, clk cycles from cs falling to start of first sclk low phase; legal 1..255
CS_HOLD, 2, clk cycles from last sclk falling to cs rising; legal 1..255
CS_IDLE, 4, minimum clk cycles cs stays high between frames; legal 1..255

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_rw  in  1  1=write, 0=read
req_addr  in  7  register address
req_wdata  in  8  write data (ignored for reads, still shifted out)
rsp_valid  out  1  one-cycle pulse: frame finished
rsp_rdata  out  8  captured read byte; 0 after write frames
busy  out  1  frame or idle gap in progress
spi_sclk  out  1  serial clock, idle low
spi_copi  out  1  serial data out
spi_cs  out  1  chip select, active low
spi_cipo  in  1  serial data in

Behaviour:
- Reset (async assert, sync deassert use): state IDLE, spi_cs=1, spi_sclk=0, spi_copi=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, all counters 0.
- All SPI outputs are registered, with no combinational path from inputs.
- States: IDLE -> SETUP -> LOW -> HIGH -> (LOW | HOLD) -> GAP -> IDLE.
- IDLE: req_ready=1, busy=0. Accept on req_valid&&req_ready at edge T0. Latch frame = {req_rw, req_addr, req_wdata}. bit_idx=15.
- SETUP: begins T0+1 with spi_cs=0 and spi_copi=frame[15]. Lasts CS_SETUP cycles. req_ready=0, busy=1.
- LOW: spi_sclk=0 for CLK_DIV cycles; spi_copi=frame[bit_idx].
- HIGH: spi_sclk=1 for CLK_DIV cycles.
  - On the clk edge where spi_sclk goes 1, sample spi_cipo into rx shift register if bit_idx<=7.
  - At end of HIGH: if bit_idx==0 go HOLD, else bit_idx-=1 and go LOW. spi_copi updates on the same edge sclk falls.
- HOLD: spi_sclk=0, spi_copi=0, spi_cs=0 for CS_HOLD cycles.
- Leaving HOLD: spi_cs=1, rsp_valid=1 for exactly that one cycle, rsp_rdata = rx byte if frame rw==0 else 8'h00. Enter GAP.
- GAP: spi_cs=1, CS_IDLE cycles, req_ready=0, busy=1, then IDLE.
- rsp_rdata holds its value until the next rsp_valid.
- Timing:
  - spi_cs low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles.
  - First sclk rise at T0+1+CS_SETUP+CLK_DIV.
  - Next accept no earlier than CS_IDLE cycles after cs rises.
  - Defaults: cs low 132 cycles.
- Exactly 16 rising sclk edges per frame; never a partial frame except on reset.
- req_* inputs are don't-care while req_ready=0; a held req_valid is accepted on the first IDLE cycle.
- Reset mid-frame: outputs return to reset values immediately (cs rises asynchronously). The frame is dropped, no rsp_valid is produced, and the peripheral discards the partial frame (<16 bits).
- Counters: one 8-bit phase counter reloaded per state, one 4-bit bit_idx; no wrap beyond 0.

Test Plan:
1. Write rw=1 addr=0x04 wdata=0x80, defaults -> copi bits 1000_0100_1000_0000 stable across each sclk rise; cs low 132 cycles; first rise at T0+7; rsp_valid one pulse at cs rise; rsp_rdata=0x00.
2. Read rw=0 addr=0x02 with cipo model driving 0xA5 MSB first, changing on sclk fall -> rsp_rdata=0xA5; copi bits 0000_0010 then req_wdata.
3. req_valid held high for 3 frames back-to-back -> req_ready low from T0+1 until CS_IDLE cycles after each cs rise; cs high exactly 4 cycles between frames; 3 rsp_valid pulses.
4. Assert rst_n low after 7 sclk rises -> cs=1, sclk=0, copi=0 within same cycle; no rsp_valid. Next write 0x00<-0xFF completes normally.
5. CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_IDLE=1 -> sclk toggles every cycle; cs low 34 cycles; 16 rises; correct bits.
6. Loopback to the SPI register-file peripheral, same clk, defaults: writes addr 0x00..0x04 with 0xF0,0xCC,0xAA,0x55,0x80, plus addr 0x05 and a read frame -> peripheral registers hold the five values; the 0x05 write and the read frame change nothing.
